// File: rtl/ifetch_queue.sv
// Instruction fetch stage: holds the PC, fetches from a combinational instruction
// memory into a small FIFO and presents {pc, instruction} to decode with valid/ready.
module ifetch_queue #(
    parameter int             WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int             IMEM_WORDS = 1024,
    parameter int             DEPTH      = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_adr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic             fault,
    output logic [WIDTH-1:0] fault_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [WIDTH:0] PC_LIMIT = (WIDTH+1)'(64'(IMEM_WORDS) * 64'd4);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  pc_r;
    logic [CW-1:0]     count_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic              fault_r;
    logic [WIDTH-1:0]  fault_pc_r;
    logic [WIDTH-1:0]  pc_q_r    [DEPTH];
    logic [WIDTH-1:0]  instr_q_r [DEPTH];

    logic              pop_s;
    logic              legal_s;
    logic              flush_s;
    logic              push_s;

    // Word-aligned and inside the instruction memory window.
    function automatic logic pc_is_legal(input logic [WIDTH-1:0] pc);
        return (pc[1:0] == 2'b00) && ({1'b0, pc} < PC_LIMIT);
    endfunction

    assign pop_s   = out_valid & out_ready;
    assign legal_s = pc_is_legal(pc_r);
    assign flush_s = (state_r == ST_RUN) & redirect_valid;
    // A full queue can still accept when the head leaves in the same cycle.
    assign push_s  = (state_r == ST_RUN) & ~redirect_valid & legal_s &
                     ((count_r < DEPTH_C) | pop_s);

    // Fetch control: PC advance, redirect and fault capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            fault_r    <= 1'b0;
            fault_pc_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc;
                    end else if (!legal_s) begin
                        state_r    <= ST_FAULT;
                        fault_r    <= 1'b1;
                        fault_pc_r <= pc_r;
                    end else if (push_s) begin
                        pc_r <= pc_r + WIDTH'(4);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                    fault_r <= 1'b1;
                end
                default: begin
                    // Corrupted state encoding is treated as a fault.
                    state_r    <= ST_FAULT;
                    fault_r    <= 1'b1;
                    fault_pc_r <= pc_r;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers; a redirect discards everything queued.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            count_r  <= {CW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Entry storage; cleared on reset so an empty queue reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= {WIDTH{1'b0}};
                instr_q_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            pc_q_r[wr_ptr_r]    <= pc_r;
            instr_q_r[wr_ptr_r] <= imem_data;
        end
    end

    assign imem_adr  = pc_r;
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_pc    = pc_q_r[rd_ptr_r];
    assign out_instr = instr_q_r[rd_ptr_r];
    assign fault     = fault_r;
    assign fault_pc  = fault_pc_r;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue; instruction memory returns
// 0x1000_0000 + address so every instruction word identifies its own PC.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_adr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int total = 0;
    int bad   = 0;

    ifetch_queue #(
        .WIDTH(32), .RESET_PC(32'h0000_0000), .IMEM_WORDS(1024), .DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .imem_adr(imem_adr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    assign imem_data = 32'h1000_0000 + imem_adr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0h exp=0", fault); end
        total++; if (fault_pc !== 32'h0) begin bad++; $display("FAIL reset_fault_pc got=%0h exp=0", fault_pc); end
        total++; if (imem_adr !== 32'h0) begin bad++; $display("FAIL reset_adr got=%0h exp=0", imem_adr); end
        total++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin bad++; $display("FAIL reset_entries pc=%0h instr=%0h exp=0/0", out_pc, out_instr); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== 32'h1000_0000 + 32'(4*i) || fault !== 1'b0) begin
                bad++;
                $display("FAIL stream[%0d] valid=%0h pc=%0h instr=%0h fault=%0h exp 1/%0h/%0h/0",
                         i, out_valid, out_pc, out_instr, fault, 4*i, 32'h1000_0000 + 32'(4*i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        repeat (5) step();
        total++; if (imem_adr !== 32'h8) begin bad++; $display("FAIL bp_hold_adr got=%0h exp=8", imem_adr); end
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL bp_hold_head valid=%0h pc=%0h exp 1/0", out_valid, out_pc); end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instr !== 32'h1000_0000 + 32'(4*k)) begin
                bad++;
                $display("FAIL bp_drain[%0d] valid=%0h pc=%0h instr=%0h exp 1/%0h", k, out_valid, out_pc, out_instr, 4*k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush valid=%0h exp=0", out_valid); end
        total++; if (imem_adr !== 32'h40) begin bad++; $display("FAIL redir_adr got=%0h exp=40", imem_adr); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1000_0040) begin bad++; $display("FAIL redir_first valid=%0h pc=%0h instr=%0h exp 1/40/10000040", out_valid, out_pc, out_instr); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin bad++; $display("FAIL redir_second valid=%0h pc=%0h exp 1/44", out_valid, out_pc); end
    endtask

    task automatic test_fault_redirect();
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL misalign_early fault=%0h exp=0", fault); end
        step();
        total++; if (fault !== 1'b1 || fault_pc !== 32'h42) begin bad++; $display("FAIL misalign_fault fault=%0h fault_pc=%0h exp 1/42", fault, fault_pc); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL misalign_valid got=%0h exp=0", out_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (imem_adr !== 32'h42 || out_valid !== 1'b0 || fault !== 1'b1) begin bad++; $display("FAIL fault_ignores_redir adr=%0h valid=%0h fault=%0h exp 42/0/1", imem_adr, out_valid, fault); end
    endtask

    task automatic fill_to_range_fault();
        do_reset();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFF8;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_range_end();
        fill_to_range_fault();
        total++; if (fault !== 1'b1 || fault_pc !== 32'h1000) begin bad++; $display("FAIL range_fault fault=%0h fault_pc=%0h exp 1/1000", fault, fault_pc); end
        total++; if (out_valid !== 1'b1 || out_pc !== 32'hFF8) begin bad++; $display("FAIL range_head valid=%0h pc=%0h exp 1/ff8", out_valid, out_pc); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'hFFC || out_instr !== 32'h1000_0FFC) begin bad++; $display("FAIL range_drain valid=%0h pc=%0h instr=%0h exp 1/ffc/10000ffc", out_valid, out_pc, out_instr); end
        step();
        total++; if (out_valid !== 1'b0 || imem_adr !== 32'h1000) begin bad++; $display("FAIL range_empty valid=%0h adr=%0h exp 0/1000", out_valid, imem_adr); end
    endtask

    task automatic test_reset_in_fault();
        fill_to_range_fault();
        total++; if (fault !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset fault=%0h valid=%0h exp 1/1", fault, out_valid); end
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        reset = 1'b0; redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || fault !== 1'b0 || fault_pc !== 32'h0 || imem_adr !== 32'h0) begin bad++; $display("FAIL fault_reset valid=%0h fault=%0h fault_pc=%0h adr=%0h exp 0/0/0/0", out_valid, fault, fault_pc, imem_adr); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin bad++; $display("FAIL fault_resume valid=%0h pc=%0h instr=%0h exp 1/0/10000000", out_valid, out_pc, out_instr); end
        step();
        total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL fault_resume2 pc=%0h exp=4", out_pc); end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault_redirect();
        test_range_end();
        test_reset_in_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
